// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Owner ids double as the round-robin last_winner encoding.
package dmem_arb_pkg;

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DBG = 1'b1;

   localparam int ADDR_W_DEF    = 32;
   localparam int DATA_W_DEF    = 32;
   localparam int MEM_BYTES_DEF = 40;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker; bit 0 = CPU, bit 1 = DBG.
// On a tie the port that did not win last time is chosen.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_winner,
   input  logic       enable,
   output logic [1:0] gnt,
   output logic       winner
);

   always_comb begin
      winner = OWN_CPU;
      gnt    = 2'b00;
      if (req[0] && req[1]) begin
         winner = ~last_winner;
      end else if (req[1]) begin
         winner = OWN_DBG;
      end
      if (enable && (req != 2'b00)) begin
         gnt = (winner == OWN_DBG) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shared data-memory port sequencer: CPU/DBG round-robin, one access per 2 cycles.
// Optional alignment/range check enabled by DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_BYTES = MEM_BYTES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_done,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_done,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

   state_t            state;
   logic              owner;
   logic              we_q;
   logic              err_q;
   logic              last_winner;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic [1:0]        gnt;
   logic              winner;
   logic              take;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [ADDR_W:0]   end_addr;
   logic              err_in;

   // Grants are masked during reset so no transfer is seen while held.
   rr_arb2 u_arb (
      .req         ({dbg_req, cpu_req}),
      .last_winner (last_winner),
      .enable      ((state == IDLE) && !reset),
      .gnt         (gnt),
      .winner      (winner)
   );

   assign cpu_gnt   = gnt[0];
   assign dbg_gnt   = gnt[1];
   assign take      = |gnt;
   assign sel_we    = winner ? dbg_we    : cpu_we;
   assign sel_addr  = winner ? dbg_addr  : cpu_addr;
   assign sel_wdata = winner ? dbg_wdata : cpu_wdata;

   // Widened so addr + 3 cannot wrap past the top of the space.
   assign end_addr = {1'b0, sel_addr} + (ADDR_W+1)'(3);
   assign err_in   = ALIGN_EN &&
                     ((sel_addr[1:0] != 2'b00) || (end_addr >= LIMIT));

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_read  = (state == ACCESS) && !we_q && !err_q;
   assign mem_write = (state == ACCESS) &&  we_q && !err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= OWN_CPU;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         last_winner <= OWN_DBG;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_done    <= 1'b0;
         dbg_done    <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         cpu_done <= 1'b0;
         dbg_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (take) begin
                  state       <= ACCESS;
                  owner       <= winner;
                  we_q        <= sel_we;
                  addr_q      <= sel_addr;
                  wdata_q     <= sel_wdata;
                  err_q       <= err_in;
                  last_winner <= winner;
               end
            end
            ACCESS: begin
               state     <= IDLE;
               cpu_done  <= (owner == OWN_CPU);
               dbg_done  <= (owner == OWN_DBG);
               rsp_rdata <= (we_q || err_q) ? '0 : mem_rdata;
               rsp_err   <= err_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a done-pulse scoreboard.
// Honours DMEM_ARB_ALIGN_CHECK_EN for the alignment expectations.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;

   typedef struct packed {
      logic        dbg;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_done  (cpu_done),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_gnt   (dbg_gnt),
      .dbg_done  (dbg_done),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata)
   );

   // 40-byte little-endian memory, asynchronous read
   logic [7:0] mem [0:39];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 40; i++) mem[i] <= 8'h00;
         mem[4]  <= 8'hEF; mem[5]  <= 8'hBE;
         mem[6]  <= 8'hAD; mem[7]  <= 8'hDE;
         mem[16] <= 8'h0D; mem[17] <= 8'hF0;
         mem[18] <= 8'hFE; mem[19] <= 8'hCA;
      end else if (mem_write && mem_addr <= 32'd36) begin
         mem[mem_addr[5:0]]        <= mem_wdata[7:0];
         mem[mem_addr[5:0] + 6'd1] <= mem_wdata[15:8];
         mem[mem_addr[5:0] + 6'd2] <= mem_wdata[23:16];
         mem[mem_addr[5:0] + 6'd3] <= mem_wdata[31:24];
      end
   end

   always_comb begin
      mem_rdata = '0;
      if (mem_addr <= 32'd36)
         mem_rdata = {mem[mem_addr[5:0] + 6'd3], mem[mem_addr[5:0] + 6'd2],
                      mem[mem_addr[5:0] + 6'd1], mem[mem_addr[5:0]]};
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic d, input logic [31:0] r, input logic e);
      exp_t x;
      x.dbg = d; x.rdata = r; x.err = e;
      sb.push_back(x);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every done pulse must match the oldest expected response
   always @(negedge clk) begin
      if (!reset && (cpu_done || dbg_done)) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("done_owner", {30'd0, cpu_done, dbg_done},
                e.dbg ? 32'd1 : 32'd2);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
      chk("rst_dbg_gnt", 32'(dbg_gnt), 0);
      chk("rst_cpu_done", 32'(cpu_done), 0);
      chk("rst_dbg_done", 32'(dbg_done), 0);
      chk("rst_mem_read", 32'(mem_read), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      reset = 1'b0;
      tick();

      // single CPU read of word 4
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'd4;
      #1;
      chk("rd_cpu_gnt", 32'(cpu_gnt), 1);
      chk("rd_dbg_gnt", 32'(dbg_gnt), 0);
      chk("rd_idle_mem_read", 32'(mem_read), 0);
      push(0, 32'hDEADBEEF, 0);
      tick();
      cpu_req = 0;
      chk("rd_mem_read", 32'(mem_read), 1);
      chk("rd_mem_write", 32'(mem_write), 0);
      chk("rd_mem_addr", mem_addr, 32'd4);
      chk("rd_access_gnt", 32'(cpu_gnt), 0);
      tick();
      chk("rd_cpu_done", 32'(cpu_done), 1);
      chk("rd_rdata", rsp_rdata, 32'hDEADBEEF);
      tick();
      chk("rd_done_drop", 32'(cpu_done), 0);
      chk("rd_rdata_hold", rsp_rdata, 32'hDEADBEEF);
      chk("rd_idle_read", 32'(mem_read), 0);
      chk("rd_addr_hold", mem_addr, 32'd4);

      // DBG write then CPU read-back
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'd8; dbg_wdata = 32'h12345678;
      #1;
      chk("wr_dbg_gnt", 32'(dbg_gnt), 1);
      chk("wr_cpu_gnt", 32'(cpu_gnt), 0);
      push(1, 32'h0, 0);
      tick();
      dbg_req = 0; dbg_we = 0;
      chk("wr_mem_write", 32'(mem_write), 1);
      chk("wr_mem_read", 32'(mem_read), 0);
      chk("wr_mem_addr", mem_addr, 32'd8);
      chk("wr_mem_wdata", mem_wdata, 32'h12345678);
      tick();
      chk("wr_dbg_done", 32'(dbg_done), 1);
      chk("wr_write_drop", 32'(mem_write), 0);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'd8;
      #1;
      chk("rb_cpu_gnt", 32'(cpu_gnt), 1);
      push(0, 32'h12345678, 0);
      tick();
      cpu_req = 0;
      chk("rb_mem_read", 32'(mem_read), 1);
      chk("rb_mem_write", 32'(mem_write), 0);
      tick();
      chk("rb_cpu_done", 32'(cpu_done), 1);
      tick();

      // DBG request arrives during CPU's ACCESS
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'd16;
      #1;
      chk("ra_cpu_gnt", 32'(cpu_gnt), 1);
      push(0, 32'hCAFEF00D, 0);
      tick();
      cpu_req = 0;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'd4;
      #1;
      chk("ra_wait_gnt", 32'(dbg_gnt), 0);
      tick();
      chk("ra_cpu_done", 32'(cpu_done), 1);
      chk("ra_dbg_gnt", 32'(dbg_gnt), 1);
      push(1, 32'hDEADBEEF, 0);
      tick();
      dbg_req = 0;
      chk("ra_mem_read", 32'(mem_read), 1);
      chk("ra_mem_addr", mem_addr, 32'd4);
      tick();
      chk("ra_dbg_done", 32'(dbg_done), 1);
      tick();

      // continuous contention from reset
      reset = 1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'd4;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'd16;
      #1;
      chk("ct_rst_gnt", {30'd0, cpu_gnt, dbg_gnt}, 0);
      tick();
      reset = 0;
      #1;
      for (int k = 0; k < 6; k++) begin
         logic own;
         own = k[0];
         chk("ct_cpu_gnt", 32'(cpu_gnt), 32'(!own));
         chk("ct_dbg_gnt", 32'(dbg_gnt), 32'(own));
         push(own, own ? 32'hCAFEF00D : 32'hDEADBEEF, 0);
         tick();
         if (k == 5) begin
            cpu_req = 0;
            dbg_req = 0;
         end
         chk("ct_mem_read", 32'(mem_read), 1);
         chk("ct_mem_addr", mem_addr, own ? 32'd16 : 32'd4);
         tick();
         chk("ct_done", {30'd0, cpu_done, dbg_done}, own ? 32'd1 : 32'd2);
      end
      tick();

      // reset in the middle of a write ACCESS
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'd12; cpu_wdata = 32'hA5A5A5A5;
      #1;
      chk("rm_cpu_gnt", 32'(cpu_gnt), 1);
      tick();
      cpu_req = 0; cpu_we = 0;
      chk("rm_mem_write", 32'(mem_write), 1);
      #1;
      reset = 1;
      #1;
      chk("rm_write_async", 32'(mem_write), 0);
      chk("rm_read_async", 32'(mem_read), 0);
      chk("rm_mem_addr", mem_addr, 0);
      chk("rm_mem_wdata", mem_wdata, 0);
      chk("rm_gnt", 32'(cpu_gnt), 0);
      tick();
      reset = 0;
      chk("rm_no_done0", {30'd0, cpu_done, dbg_done}, 0);
      tick();
      chk("rm_no_done1", {30'd0, cpu_done, dbg_done}, 0);
      chk("rm_idle_write", 32'(mem_write), 0);

      // misaligned and out-of-range reads
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'd6;
      #1;
      chk("al6_gnt", 32'(cpu_gnt), 1);
      push(0, ALIGN ? 32'h0 : 32'h0000DEAD, ALIGN);
      tick();
      cpu_req = 0;
      chk("al6_mem_read", 32'(mem_read), 32'(!ALIGN));
      chk("al6_mem_write", 32'(mem_write), 0);
      tick();
      chk("al6_done", 32'(cpu_done), 1);
      chk("al6_err", 32'(rsp_err), 32'(ALIGN));
      tick();
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'd40;
      #1;
      chk("al40_gnt", 32'(dbg_gnt), 1);
      push(1, 32'h0, ALIGN);
      tick();
      dbg_req = 0;
      chk("al40_mem_read", 32'(mem_read), 32'(!ALIGN));
      tick();
      chk("al40_done", 32'(dbg_done), 1);
      tick();

      chk("sb_drained", 32'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the shared byte-addressable data memory of the pipelined MIPS32 core. It shares the single memory port between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port), using a round-robin grant. Each accepted request is latched, driven to the memory for exactly one access cycle, and answered with a registered read-data/done pulse. The block sits between the MEM stage and the data memory. It drives the memory's Address, WriteData, MemRead and MemWrite, and samples its ReadData.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, word width (4 bytes, little-endian byte lanes)
- MEM_BYTES, 40, memory size in bytes; used only by the alignment check
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cpu_req / dbg_req  in  1  request valid; held until granted
- cpu_we / dbg_we  in  1  1 = write, 0 = read
- cpu_addr / dbg_addr  in  ADDR_W  byte address
- cpu_wdata / dbg_wdata  in  DATA_W  write data
- cpu_gnt / dbg_gnt  out  1  combinational accept; transfer occurs on req && gnt
- cpu_done / dbg_done  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, valid with either done pulse
- rsp_err  out  1  access error, valid with either done pulse
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory WriteData
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  DATA_W  from memory ReadData (asynchronous read)

## Operation
- FSM has two states: IDLE and ACCESS. At most one transaction is outstanding.
- In IDLE, grants are combinational:
  - Only one requester active: it is granted.
  - Both active: grant goes to the port that is not last_winner.
- On a transfer, the block latches owner, we, addr and wdata, updates last_winner, and moves to ACCESS.
- In ACCESS:
  - mem_addr and mem_wdata are driven from the latch.
  - mem_write = latched we.
  - mem_read = !latched we.
  - Both gnt outputs are 0.
  - Next state is IDLE unconditionally.
- On leaving ACCESS:
  - The owner's done pulses for one cycle.
  - For a read, rsp_rdata is registered from mem_rdata. For a write, rsp_rdata = 0.
  - rsp_err is registered (see Configuration).
- rsp_rdata holds its value until the next done pulse.
- Outside ACCESS, mem_read and mem_write are 0, and mem_addr and mem_wdata hold their last values.
- The CPU stalls the pipeline while cpu_req && !cpu_gnt, or until cpu_done.
- Reset values:
  - state = IDLE, last_winner = DBG (so the CPU wins the first tie).
  - All gnt and done outputs = 0, mem_read = mem_write = 0.
  - mem_addr, mem_wdata, rsp_rdata = 0; rsp_err = 0.

## Timing
- Request accepted in cycle N, memory strobes active in N+1, done and rsp_rdata valid in N+2.
- Sustained throughput is one access per 2 cycles. A new grant can occur in the same cycle as the previous done.
- Under continuous contention, accesses alternate strictly CPU, DBG, CPU, ...
- A request that arrives during ACCESS waits for IDLE; no request is ever dropped.
- Reset asserted mid-ACCESS:
  - mem_write and mem_read drop immediately (asynchronous).
  - No done pulse is produced.
  - The transaction is lost.

## Configuration
- DMEM_ARB_ALIGN_CHECK_EN defined:
  - An access errors if addr[1:0] != 0 or addr + 3 >= MEM_BYTES.
  - On error, ACCESS still takes one cycle, but mem_read and mem_write stay 0.
  - The done pulse carries rsp_err = 1 and rsp_rdata = 0.
- Not defined: there is no check, rsp_err is tied to 0, and all addresses pass through.

## Structure
- Package dmem_arb_pkg holds:
  - State enum {IDLE, ACCESS}.
  - Owner encoding: OWN_CPU = 0, OWN_DBG = 1.
  - Default widths.
- One sub-module, rr_arb2: a two-requester round-robin picker. Inputs are the two reqs, last_winner and enable. Outputs are one-hot gnt and the winner id.

## Test plan
- Single CPU read: memory word 0x04 preloaded with 0xDEADBEEF; cpu_req=1, we=0, addr=4 -> cpu_gnt in N, mem_read=1 with mem_addr=4 in N+1, cpu_done with rsp_rdata=0xDEADBEEF in N+2.
- DBG write then CPU read: DBG writes 0x12345678 to addr 8; CPU then reads 8 -> mem_write only in DBG's ACCESS cycle; CPU read returns 0x12345678.
- Contention: cpu_req and dbg_req held high from reset for 6 accesses -> grants go CPU, DBG, CPU, DBG, CPU, DBG; each done lands 2 cycles after its gnt.
- Request during ACCESS: dbg_req rises in the CPU's ACCESS cycle -> dbg_gnt in the next cycle, coincident with cpu_done.
- Reset mid-ACCESS on a write to addr 12 -> mem_write falls asynchronously, no done pulse, state is IDLE and outputs are at reset values.
- With DMEM_ARB_ALIGN_CHECK_EN: read at addr 6, then at addr 40 -> mem_read stays 0, done with rsp_err=1 and rsp_rdata=0. Without the macro, addr 6 produces mem_read=1 and rsp_err=0.
